// File: rtl/flop_debounce_edge_pkg.sv
// -----------------------------------------------------------------------------
// flop_debounce_edge_pkg
//
// Shared types and default constants for the flop_debounce_edge block.
//   state_e           : filter FSM state (StStable = 1'b0, StCheck = 1'b1)
//   DEF_SYNC_STAGES   : default synchroniser depth
//   DEF_STABLE_CYCLES : default number of consecutive differing samples
//                       needed before the clean level changes
// -----------------------------------------------------------------------------
package flop_debounce_edge_pkg;

  typedef enum logic {
    StStable = 1'b0,
    StCheck  = 1'b1
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/flop_debounce_edge_sync_chain.sv
// -----------------------------------------------------------------------------
// flop_debounce_edge_sync_chain
//
// SYNC_STAGES-deep shift register that brings a raw, possibly asynchronous
// bit into the clk domain. It shifts on every edge; there is no enable.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (clears every stage)
//   d_i : raw input bit
//   s_o : synchronised bit (last stage of the chain)
// -----------------------------------------------------------------------------
module flop_debounce_edge_sync_chain
  import flop_debounce_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES  // legal range 2..4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Bit 0 is the metastability-catching stage; the MSB is the output.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/flop_debounce_edge.sv
// -----------------------------------------------------------------------------
// flop_debounce_edge
//
// Debounces the raw single-bit output of an upstream flop. The input is
// synchronised, then a two-state filter only accepts a new level after
// STABLE_CYCLES consecutive enabled samples that differ from the current
// level. Each accepted change produces a one-cycle rise or fall pulse.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset; wins over en and d
//   d     : raw input, driven by the upstream flop's q
//   en    : filter enable; 0 freezes state, count and level
//   level : debounced level, registered
//   rise  : one-cycle pulse on level 0->1, registered
//   fall  : one-cycle pulse on level 1->0, registered
//   busy  : high while a candidate change is being counted
// -----------------------------------------------------------------------------
module flop_debounce_edge
  import flop_debounce_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,   // legal range 2..4
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES  // legal range 1..255
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  // Count value at which the next differing sample commits the change.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  // Reject illegal parameterisations at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("flop_debounce_edge: SYNC_STAGES must be in 2..4");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : gen_bad_stable_cycles
    $error("flop_debounce_edge: STABLE_CYCLES must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic s;

  flop_debounce_edge_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk (clk),
    .rst (rst),
    .d_i (d),
    .s_o (s)
  );

  // ---------------------------------------------------------------------------
  // Filter FSM, counter and pulse generation
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic             commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    // An unknown s makes (s != level_q) unknown, so the if takes the
    // else/no-change path and level is never corrupted by X.
    if (en) begin
      case (state_q)
        StStable: begin
          if (s != level_q) begin
            if (STABLE_CYCLES == 1) begin
              commit = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          if (s != level_q) begin
            if (cnt_q == CntLast) begin
              commit = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            // Sample agreed with level again: the candidate was a glitch.
            cnt_d   = '0;
            state_d = StStable;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StStable;
        end
      endcase
    end

    if (commit) begin
      level_d = s;
      rise_d  = s;
      fall_d  = ~s;
      cnt_d   = '0;
      state_d = StStable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStable;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = (state_q == StCheck);

endmodule

// File: tb/tb_flop_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_flop_debounce_edge
//
// Directed steps from the test plan followed by a randomised phase. Every
// edge is also compared against a run-length reference model: the clean
// level flips after STABLE consecutive enabled synchronised samples that
// differ from it; any enabled agreeing sample clears the run.
// -----------------------------------------------------------------------------
module tb_flop_debounce_edge;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'bx;
  logic en  = 1'b1;
  logic level, rise, fall, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic        pipe_m[$];
  logic        level_m = 1'b0;
  logic        rise_m  = 1'b0;
  logic        fall_m  = 1'b0;
  int unsigned run_m   = 0;

  flop_debounce_edge #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .en    (en),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe_m.delete();
    for (int i = 0; i < int'(SYNC); i++) pipe_m.push_back(1'b0);
    level_m = 1'b0;
    rise_m  = 1'b0;
    fall_m  = 1'b0;
    run_m   = 0;
  endtask

  // One clock edge of the reference: the filter sees the sample that has
  // already travelled SYNC edges down the delay line.
  task automatic model_step(input logic md, input logic men, input logic mrst);
    logic s;
    if (mrst) begin
      model_reset();
      return;
    end
    s = pipe_m[SYNC-1];
    void'(pipe_m.pop_back());
    pipe_m.push_front(md);
    rise_m = 1'b0;
    fall_m = 1'b0;
    if (men) begin
      if (s === ~level_m) begin
        run_m++;
        if (run_m == STABLE) begin
          level_m = ~level_m;
          rise_m  = level_m;
          fall_m  = ~level_m;
          run_m   = 0;
        end
      end else begin
        run_m = 0;
      end
    end
  endtask

  // Drive inputs midway between edges, step the model on the edge, sample
  // 1 time unit after it.
  task automatic tick(input logic nd, input logic nen, input logic nrst);
    @(negedge clk);
    d   = nd;
    en  = nen;
    rst = nrst;
    @(posedge clk);
    model_step(nd, nen, nrst);
    #1;
    chk("model.level", level, level_m);
    chk("model.rise", rise, rise_m);
    chk("model.fall", fall, fall_m);
    chk("model.busy", busy, (run_m != 0));
    chk("model.no_double_pulse", rise & fall, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic el, input logic er,
                            input logic ef, input logic eb);
    chk({tag, ".level"}, level, el);
    chk({tag, ".rise"}, rise, er);
    chk({tag, ".fall"}, fall, ef);
    chk({tag, ".busy"}, busy, eb);
  endtask

  initial begin
    int   remaining;
    logic rd;
    remaining = 0;
    rd        = 1'b0;
    model_reset();

    // Reset with unknown input, then released with d still unknown.
    tick(1'bx, 1'b1, 1'b1);
    tick(1'bx, 1'b1, 1'b1);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'bx, 1'b1, 1'b0);
      expect_out($sformatf("post_reset_x[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) tick(1'b0, 1'b1, 1'b0);

    // Clean rise: level and rise at E+5.
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      expect_out($sformatf("rise[%0d]", i), (i >= 5), (i == 5), 1'b0, (i >= 2 && i <= 4));
    end
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // Clean fall: fall pulse at E+5.
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      expect_out($sformatf("fall[%0d]", i), (i < 5), 1'b0, (i == 5), (i >= 2 && i <= 4));
    end
    repeat (2) tick(1'b0, 1'b1, 1'b0);

    // Three-cycle glitch is rejected.
    for (int i = 0; i < 8; i++) begin
      tick((i < 3), 1'b1, 1'b0);
      expect_out($sformatf("glitch[%0d]", i), 1'b0, 1'b0, 1'b0, (i >= 2 && i <= 4));
    end

    // Enable frozen over edges E+3..E+7 delays the commit to E+10.
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, !(i >= 3 && i <= 7), 1'b0);
      expect_out($sformatf("freeze[%0d]", i), (i >= 10), (i == 10), 1'b0, (i >= 2 && i <= 9));
    end

    repeat (8) tick(1'b0, 1'b1, 1'b0);
    expect_out("return_low", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a count.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    expect_out("pre_mid_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    expect_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 7; j++) begin
      tick(1'b1, 1'b1, 1'b0);
      expect_out($sformatf("after_rst[%0d]", j), (j >= 5), (j == 5), 1'b0, (j >= 2 && j <= 4));
    end

    // Random bursts of varying length, occasional enable drops and resets.
    for (int k = 0; k < 400; k++) begin
      if (remaining == 0) begin
        rd        = 1'($urandom_range(0, 1));
        remaining = int'($urandom_range(1, 7));
      end
      remaining--;
      tick(rd, ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
